wb_stage: RTL
=============

# wb_stage

Write-back stage of the three-stage pipelined MIPS core. Accepts retiring instructions from the execute stage, waits for load data when needed, and drives the register file's per-register write strobes (one-hot select, write enable, write data). The per-register latches capture on the falling clock edge, so every write this block issues lands mid-cycle. It also provides a forwarding tap and a retired-instruction counter.

## Interface
- `DATA_W`, default 32: datapath width.
- `ADDR_W`, default 5: register address width.
- `NREG`, default 32: number of architectural registers; equals 2**`ADDR_W`.

- `clk` in 1: single clock. The block updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: the execute stage presents an instruction.
- `ex_ready` out 1: this block can accept an instruction this cycle.
- `ex_rd` in `ADDR_W`: destination register.
- `ex_reg_write` in 1: the instruction writes a register.
- `ex_is_load` in 1: the result comes from memory.
- `ex_result` in `DATA_W`: ALU result.
- `mem_rdata` in `DATA_W`: load data.
- `mem_rvalid` in 1: `mem_rdata` is valid this cycle.
- `flush` in 1: kill any uncommitted instruction.
- `wb_data` out `DATA_W`: register-file write data.
- `wb_select` out `NREG`: one-hot register select.
- `wb_write` out 1: register-file write enable.
- `fwd_valid` out 1: the forwarding tap is valid.
- `fwd_rd` out `ADDR_W`: forwarded destination register.
- `fwd_data` out `DATA_W`: forwarded value.
- `retired` out 32: count of retired instructions.

## Operation
- **States:** `WB_IDLE`, `WB_COMMIT`, `WB_WAIT_MEM`.
- **Accept:** an instruction is accepted when `ex_valid && ex_ready && !flush` is true at a rising edge. The block latches `ex_rd`, `ex_reg_write` and `ex_result`.
- **`ex_ready`:** 1 in `WB_IDLE` and `WB_COMMIT`; 0 in `WB_WAIT_MEM` and while `rst_n` is low.
- **Transitions on accept:**
  - Non-load: go to `WB_COMMIT`.
  - Load: go to `WB_WAIT_MEM`.
- **`WB_WAIT_MEM`:**
  - Sample `mem_rvalid` every edge.
  - When it is 1, capture `mem_rdata` as the result and go to `WB_COMMIT`.
  - When it is 0, stay in `WB_WAIT_MEM`.
- **`WB_COMMIT` (exactly one cycle per instruction):**
  - `wb_data` = latched result.
  - `wb_select` = one-hot of rd.
  - `wb_write` = `reg_write && (rd != 0)`.
  - If rd == 0 or reg_write == 0: `wb_select` = 0 and `wb_write` = 0.
  - The instruction still retires: `retired` increments on the leaving edge.
  - If a new instruction is accepted on that same edge, the next state follows that instruction's type (back-to-back throughput of 1 per cycle for ALU ops). Otherwise the next state is `WB_IDLE`.
- **Outside `WB_COMMIT`:** `wb_write` = 0 and `wb_select` = 0. `wb_data` holds its last value.
- **Forwarding tap:**
  - `fwd_valid` = `WB_COMMIT && wb_write`.
  - `fwd_rd` and `fwd_data` mirror the committing rd and data.
- **`flush`:**
  - In `WB_WAIT_MEM`: go to `WB_IDLE` with no write and no retire. A `mem_rvalid` arriving in the same cycle is ignored.
  - In `WB_COMMIT`: does not cancel the commit, because the commit is already architectural.
  - Always blocks any accept in the same cycle.
- **`retired`:** wraps from 2^32-1 to 0.

## Timing
- **Reset:** `rst_n` low asynchronously forces the following, regardless of `clk`:
  - State = `WB_IDLE`.
  - `wb_data` = 0, `wb_select` = 0, `wb_write` = 0.
  - `fwd_valid` = 0, `fwd_rd` = 0, `fwd_data` = 0.
  - `retired` = 0.
- **Reset mid-operation:** a pending load is discarded and no write occurs.
- **Release:** first accept is possible at the first rising edge after `rst_n` goes high.
- **Latency:**
  - ALU op: accepted at edge N; `wb_write` high in cycle N..N+1; the register latches capture on the falling edge in that cycle.
  - Load: if `mem_rvalid` is seen at edge M, the commit is in cycle M..M+1.
- **Output registers:** all outputs except `ex_ready` are registered. `ex_ready` is a function of state only.
- **Edge budget:** `wb_select`, `wb_write` and `wb_data` must be stable before the falling edge, which allows half a cycle of setup into the register latches.

## Structure
- Shared package `mips_pkg` holds:
  - `DATA_W`, `ADDR_W`, `NREG`.
  - `typedef enum {WB_IDLE, WB_COMMIT, WB_WAIT_MEM} wb_state_t`.
  - `REG_ZERO = 0`.
- One combinational sub-module, `wb_dec5to32`: rd plus enable in, one-hot `NREG` out, with the output forced to 0 when rd == 0.

## Test plan
- **Reset:** hold `rst_n` low mid-cycle with `ex_valid` = 1 -> all outputs 0, `ex_ready` = 0, `retired` = 0. Release -> `ex_ready` = 1.
- **ALU op:** accept rd = 5, result 0xDEADBEEF -> next cycle `wb_select` = 0x00000020, `wb_write` = 1, `wb_data` = 0xDEADBEEF, `fwd_valid` = 1, `retired` = 1 after.
- **Back-to-back ALU:** rd = 1, 2, 3 on consecutive edges -> three consecutive commit cycles with selects 0x2, 0x4, 0x8 and no bubble.
- **Load:** load to rd = 7 with `mem_rvalid` low for 3 cycles, then 0x12345678 -> `ex_ready` = 0 while waiting; commit `wb_select` = 0x80, `wb_data` = 0x12345678.
- **$0 write:** rd = 0 with `reg_write` = 1 -> `wb_write` = 0, `wb_select` = 0, `retired` still increments.
- **Flush:** flush during `WB_WAIT_MEM` with `mem_rvalid` = 1 in the same cycle -> no write, `retired` unchanged, state `WB_IDLE`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the three-stage MIPS core pipeline.
// Widths, write-back state encoding and the hard-wired zero register.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_COMMIT   = 2'd1,
        WB_WAIT_MEM = 2'd2
    } wb_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_dec5to32.sv
// Register-select decoder: one-hot of rd when enabled, never selecting $0.
module wb_dec5to32
    import mips_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic [ADDR_W-1:0] rd,
    input  logic              en,
    output logic [NREG-1:0]   sel
);

    // One-hot select; $0 is hard-wired so it is never strobed
    always_comb begin
        sel = {NREG{1'b0}};
        if (en && (rd != ADDR_W'(REG_ZERO))) begin
            sel[rd] = 1'b1;
        end else begin
            sel = {NREG{1'b0}};
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires execute-stage results (waiting on load data when
// needed), strobes the register file, and exposes a forwarding tap.
module wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic              flush,
    output logic [DATA_W-1:0] wb_data,
    output logic [NREG-1:0]   wb_select,
    output logic              wb_write,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retired
);

    wb_state_t         state_r;
    logic [ADDR_W-1:0] rd_r;
    logic              rw_r;

    logic              accept_s;
    logic              go_commit_s;
    logic              go_wait_s;
    logic [ADDR_W-1:0] dec_rd_s;
    logic              dec_en_s;
    logic [DATA_W-1:0] commit_data_s;
    logic [NREG-1:0]   sel_s;

    assign ex_ready = rst_n && (state_r != WB_WAIT_MEM);
    assign accept_s = ex_valid && ex_ready && !flush;

    // Pick the instruction that would commit next: the parked load or the incoming op
    always_comb begin
        if (state_r == WB_WAIT_MEM) begin
            dec_rd_s      = rd_r;
            dec_en_s      = rw_r;
            commit_data_s = mem_rdata;
            go_commit_s   = !flush && mem_rvalid;
            go_wait_s     = !flush && !mem_rvalid;
        end else begin
            dec_rd_s      = ex_rd;
            dec_en_s      = ex_reg_write;
            commit_data_s = ex_result;
            go_commit_s   = accept_s && !ex_is_load;
            go_wait_s     = accept_s && ex_is_load;
        end
    end

    wb_dec5to32 #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_dec (
        .rd  (dec_rd_s),
        .en  (dec_en_s),
        .sel (sel_s)
    );

    // State, latched instruction fields and registered register-file strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= WB_IDLE;
            rd_r      <= {ADDR_W{1'b0}};
            rw_r      <= 1'b0;
            wb_data   <= {DATA_W{1'b0}};
            wb_select <= {NREG{1'b0}};
            wb_write  <= 1'b0;
            fwd_valid <= 1'b0;
            fwd_rd    <= {ADDR_W{1'b0}};
            fwd_data  <= {DATA_W{1'b0}};
            retired   <= 32'd0;
        end else begin
            // A commit cycle always retires, even when flush is high
            if (state_r == WB_COMMIT) begin
                retired <= retired + 32'd1;
            end else begin
                retired <= retired;
            end

            if (accept_s) begin
                rd_r <= ex_rd;
                rw_r <= ex_reg_write;
            end else begin
                rd_r <= rd_r;
                rw_r <= rw_r;
            end

            if (go_commit_s) begin
                state_r   <= WB_COMMIT;
                wb_data   <= commit_data_s;
                wb_select <= sel_s;
                wb_write  <= |sel_s;
                fwd_valid <= |sel_s;
                fwd_rd    <= dec_rd_s;
                fwd_data  <= commit_data_s;
            end else begin
                state_r   <= go_wait_s ? WB_WAIT_MEM : WB_IDLE;
                wb_data   <= wb_data;
                wb_select <= {NREG{1'b0}};
                wb_write  <= 1'b0;
                fwd_valid <= 1'b0;
                fwd_rd    <= fwd_rd;
                fwd_data  <= fwd_data;
            end
        end
    end

endmodule
